// File: rtl/pwm_multi.sv
// pwm_multi -- multi-channel PWM generator with a word-addressed register file.
//
// Each channel owns a counter, ctrl bits (enable, polarity, center mode) and
// double-buffered period/duty registers. Bus writes land in shadow registers
// and are copied to the active set only at the channel's period boundary, so a
// running waveform never sees a half-updated period/duty pair.
//
// Word address = {channel, reg[2:0]}:
//   0 ctrl [0]=en [1]=polarity [2]=center   1 period hi   2 period lo
//   3 duty hi   4 duty lo   5 counter hi (RO)   6 counter lo (RO)
//   7 status [0]=update pending (RO)
//
// Ports (pwm_multi):
//   clk, reset_n     clock, asynchronous active-low reset
//   wr_en, rd_en     write / read strobes, one word per cycle
//   addr             word address
//   wr_data          write data
//   rd_data          read data, one cycle after rd_en, 0 otherwise
//   pwm_out          registered PWM output per channel
//   period_tick      one-cycle pulse per channel at each period boundary
//
// Ports (pwm_chan, one per channel):
//   wr_i/reg_i/wdata_i  decoded write for this channel
//   rdata_o             combinational readback of register reg_i
//   pwm_o, tick_o       registered channel outputs

module pwm_chan #(
   parameter int CNT_WIDTH = 32
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        wr_i,
   input  logic [2:0]  reg_i,
   input  logic [15:0] wdata_i,
   output logic [15:0] rdata_o,
   output logic        pwm_o,
   output logic        tick_o
);
   localparam int HW = CNT_WIDTH - 16;   // live bits in the hi word

   typedef logic [CNT_WIDTH-1:0] cnt_t;

   logic en_q, pol_q, ctr_q;
   cnt_t sh_per_q, sh_duty_q, per_q, duty_q;
   cnt_t cnt_q, cnt_d;
   logic dir_q, dir_d;                   // 0 = counting up, 1 = counting down
   logic pend_q, pwm_q, tick_q;
   logic pwm_d, tick_d;
   logic per_zero, bnd, raw, commit, restart, sh_wr;

   always_comb begin
      per_zero = (per_q == '0);
      sh_wr    = wr_i && (reg_i >= 3'd1) && (reg_i <= 3'd4);
      // Toggling enable or switching mode throws the counter back to the start.
      restart  = wr_i && (reg_i == 3'd0) &&
                 ((wdata_i[0] != en_q) || (wdata_i[2] != ctr_q));
      // In center mode the counter only sits at 0 at the bottom of the down
      // slope or right after a restart, so cnt==0 alone marks the boundary.
      if (per_zero)   bnd = 1'b0;
      else if (ctr_q) bnd = (cnt_q == '0);
      else            bnd = (cnt_q == per_q - cnt_t'(1));
      // A disabled or zero-period channel has no meaningful boundary, so the
      // shadow is allowed through every cycle.
      commit   = !en_q || per_zero || bnd;
      raw      = !per_zero && (cnt_q < duty_q);
      pwm_d    = en_q ? (raw ^ pol_q) : pol_q;
      tick_d   = en_q && bnd;
   end

   always_comb begin
      cnt_d = cnt_q;
      dir_d = dir_q;
      if (restart || !en_q || per_zero) begin
         cnt_d = '0;
         dir_d = 1'b0;
      end else if (!ctr_q) begin
         // >= rather than == keeps the wrap safe if cnt ever sits past the end.
         cnt_d = (cnt_q >= per_q - cnt_t'(1)) ? '0 : cnt_q + cnt_t'(1);
      end else if (!dir_q) begin
         if (cnt_q >= per_q) begin
            dir_d = 1'b1;
            cnt_d = per_q - cnt_t'(1);
         end else begin
            cnt_d = cnt_q + cnt_t'(1);
         end
      end else begin
         if (cnt_q == '0) begin
            dir_d = 1'b0;
            cnt_d = cnt_t'(1);
         end else begin
            cnt_d = cnt_q - cnt_t'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         en_q      <= 1'b0;
         pol_q     <= 1'b0;
         ctr_q     <= 1'b0;
         sh_per_q  <= '0;
         sh_duty_q <= '0;
         per_q     <= '0;
         duty_q    <= '0;
         cnt_q     <= '0;
         dir_q     <= 1'b0;
         pend_q    <= 1'b0;
         pwm_q     <= 1'b0;
         tick_q    <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         dir_q  <= dir_d;
         pwm_q  <= pwm_d;
         tick_q <= tick_d;
         // Commit copies the shadow as it was before this cycle's write, so a
         // write racing the boundary waits for the next one.
         if (commit) begin
            per_q  <= sh_per_q;
            duty_q <= sh_duty_q;
         end
         if (wr_i) begin
            case (reg_i)
               3'd0: {ctr_q, pol_q, en_q}          <= wdata_i[2:0];
               3'd1: sh_per_q[CNT_WIDTH-1:16]     <= wdata_i[HW-1:0];
               3'd2: sh_per_q[15:0]               <= wdata_i;
               3'd3: sh_duty_q[CNT_WIDTH-1:16]    <= wdata_i[HW-1:0];
               3'd4: sh_duty_q[15:0]              <= wdata_i;
               default: ;
            endcase
         end
         if (sh_wr)       pend_q <= 1'b1;
         else if (commit) pend_q <= 1'b0;
      end
   end

   always_comb begin
      rdata_o = '0;
      case (reg_i)
         3'd0: rdata_o[2:0]    = {ctr_q, pol_q, en_q};
         3'd1: rdata_o[HW-1:0] = sh_per_q[CNT_WIDTH-1:16];
         3'd2: rdata_o         = sh_per_q[15:0];
         3'd3: rdata_o[HW-1:0] = sh_duty_q[CNT_WIDTH-1:16];
         3'd4: rdata_o         = sh_duty_q[15:0];
         3'd5: rdata_o[HW-1:0] = cnt_q[CNT_WIDTH-1:16];
         3'd6: rdata_o         = cnt_q[15:0];
         default: rdata_o[0]   = pend_q;
      endcase
   end

   assign pwm_o  = pwm_q;
   assign tick_o = tick_q;
endmodule

module pwm_multi #(
   parameter int NUM_CH     = 4,
   parameter int CNT_WIDTH  = 32,
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = $clog2(NUM_CH) + 3
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  wr_en,
   input  logic                  rd_en,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic [NUM_CH-1:0]     pwm_out,
   output logic [NUM_CH-1:0]     period_tick
);
   // Channel field taken by shift so a single-channel build (no channel bits)
   // still elaborates; indices >= NUM_CH match no lane and read as 0.
   logic [ADDR_WIDTH-1:0]             ch_idx;
   logic [NUM_CH-1:0]                 sel;
   logic [NUM_CH-1:0][DATA_WIDTH-1:0] lane_rd;
   logic [DATA_WIDTH-1:0]             rd_mux, rd_data_d, rd_data_q;

   assign ch_idx = addr >> 3;

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      assign sel[c] = (ch_idx == ADDR_WIDTH'(c));
      pwm_chan #(.CNT_WIDTH(CNT_WIDTH)) u_chan (
         .clk     (clk),
         .reset_n (reset_n),
         .wr_i    (wr_en && sel[c]),
         .reg_i   (addr[2:0]),
         .wdata_i (wr_data),
         .rdata_o (lane_rd[c]),
         .pwm_o   (pwm_out[c]),
         .tick_o  (period_tick[c])
      );
   end

   always_comb begin
      rd_mux = '0;
      for (int c = 0; c < NUM_CH; c++)
         if (sel[c]) rd_mux |= lane_rd[c];
      rd_data_d = rd_en ? rd_mux : '0;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) rd_data_q <= '0;
      else          rd_data_q <= rd_data_d;
   end

   assign rd_data = rd_data_q;
endmodule

// File: tb/tb_pwm_multi.sv
// Testbench for pwm_multi: directed register writes/reads with expected
// waveforms and read data queued by the stimulus and checked by a monitor
// on the falling clock edge.
module tb_pwm_multi;
   logic        clk = 1'b0;
   logic        reset_n;
   logic        wr_en, rd_en;
   logic [5:0]  addr;
   logic [15:0] wr_data;
   logic [15:0] rd_data;
   logic [3:0]  pwm_out, period_tick;

   typedef struct { string nm; logic [15:0] exp; } rd_exp_t;
   typedef struct { string nm; logic [7:0] mask; logic [7:0] exp; } pwm_exp_t;

   rd_exp_t  rd_q[$];
   pwm_exp_t pwm_q[$];
   rd_exp_t  re;
   pwm_exp_t pe;
   int       n_vec = 0, n_fail = 0;
   logic     rd_pend;
   logic [7:0] vec;

   // 6-bit address gives a 3-bit channel field so index 5 is reachable.
   pwm_multi #(.NUM_CH(4), .CNT_WIDTH(32), .DATA_WIDTH(16), .ADDR_WIDTH(6)) dut (
      .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .rd_en(rd_en), .addr(addr),
      .wr_data(wr_data), .rd_data(rd_data), .pwm_out(pwm_out),
      .period_tick(period_tick));

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1, "timeout");
   end

   always @(posedge clk or negedge reset_n)
      if (!reset_n) rd_pend <= 1'b0;
      else          rd_pend <= rd_en;

   always @(negedge clk) begin
      if (pwm_q.size() > 0) begin
         pe  = pwm_q.pop_front();
         vec = {period_tick, pwm_out};
         n_vec++;
         if ((vec & pe.mask) !== pe.exp) begin
            n_fail++;
            $display("FAIL %s: tick/pwm got %h want %h (mask %h) t=%0t",
                     pe.nm, vec & pe.mask, pe.exp, pe.mask, $time);
         end
      end
      n_vec++;
      if (rd_pend) begin
         if (rd_q.size() == 0) begin
            n_fail++;
            $display("FAIL rd_unexpected: rd_data %h with no queued read t=%0t", rd_data, $time);
         end else begin
            re = rd_q.pop_front();
            if (rd_data !== re.exp) begin
               n_fail++;
               $display("FAIL %s: rd_data got %h want %h t=%0t", re.nm, rd_data, re.exp, $time);
            end
         end
      end else if (rd_data !== 16'h0) begin
         n_fail++;
         $display("FAIL rd_idle: rd_data got %h want 0000 t=%0t", rd_data, $time);
      end
   end

   task automatic step();
      @(posedge clk); #1;
      wr_en = 1'b0; rd_en = 1'b0;
   endtask

   task automatic drive(input bit w, input bit r, input logic [5:0] a,
                        input logic [15:0] d, input logic [15:0] rexp, input string nm);
      wr_en = w; rd_en = r; addr = a; wr_data = d;
      if (r) rd_q.push_back('{nm, rexp});
      step();
   endtask

   task automatic wr(input logic [5:0] a, input logic [15:0] d);
      drive(1'b1, 1'b0, a, d, 16'h0, "");
   endtask

   task automatic rd(input logic [5:0] a, input logic [15:0] rexp, input string nm);
      drive(1'b0, 1'b1, a, 16'h0, rexp, nm);
   endtask

   task automatic expect_pwm(input logic [7:0] mask, input logic [7:0] exp, input string nm);
      pwm_q.push_back('{nm, mask, exp});
   endtask

   task automatic hold(input int n, input logic [7:0] mask, input logic [7:0] exp, input string nm);
      for (int i = 0; i < n; i++) begin
         expect_pwm(mask, exp, nm);
         step();
      end
   endtask

   task automatic settle(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   int  d, j, v;
   logic p, t;

   initial begin
      reset_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; addr = '0; wr_data = '0;
      step();
      expect_pwm(8'hff, 8'h00, "reset_outputs");
      step();
      reset_n = 1'b1;
      rd(6'd7, 16'h0, "reset_status");
      rd(6'd2, 16'h0, "reset_per_lo");

      // ch0 edge mode, period 10 duty 3, then duty 7 written mid-period.
      wr(6'd2, 16'd10);
      wr(6'd4, 16'd3);
      wr(6'd0, 16'h0001);
      for (int c = -1; c < 50; c++) begin
         d = (c >= 20) ? 7 : 3;
         p = (c >= 0) && ((c % 10) < d);
         t = (c >= 0) && ((c % 10) == 9);
         expect_pwm(8'hff, {3'b000, t, 3'b000, p}, "ch0_edge");
         case (c)
            5:       rd(6'd2, 16'd10, "ch0_per_lo");
            11:      wr(6'd4, 16'd7);
            12:      rd(6'd7, 16'd1, "ch0_pend_set");
            14:      rd(6'd4, 16'd7, "ch0_duty_shadow");
            18:      rd(6'd7, 16'd1, "ch0_pend_at_bnd");
            19:      rd(6'd7, 16'd0, "ch0_pend_clr");
            25:      rd(6'd6, 16'd6, "ch0_cnt_lo");
            default: step();
         endcase
      end

      // ch1 center mode, period 8 duty 2: 16-cycle repetition.
      wr(6'd10, 16'd8);
      wr(6'd12, 16'd2);
      wr(6'd8, 16'h0005);
      for (int c = -1; c < 36; c++) begin
         j = (c < 0) ? 0 : (c % 16);
         v = (j <= 8) ? j : 16 - j;
         p = (c >= 0) && (v < 2);
         t = (c >= 0) && (v == 0);
         expect_pwm(8'h22, {2'b00, t, 1'b0, 2'b00, p, 1'b0}, "ch1_center");
         if (c == 10) rd(6'd14, 16'd5, "ch1_cnt_lo");
         else         step();
      end

      // ch2 boundary values, with each case also inverted by polarity.
      wr(6'd18, 16'd5);
      wr(6'd20, 16'd0);
      wr(6'd16, 16'h0001);
      settle(12); hold(6, 8'h04, 8'h00, "ch2_duty0");
      wr(6'd16, 16'h0003);
      settle(3);  hold(6, 8'h04, 8'h04, "ch2_duty0_pol1");
      wr(6'd20, 16'd5);
      settle(12); hold(6, 8'h04, 8'h00, "ch2_dutyeqper_pol1");
      wr(6'd16, 16'h0001);
      settle(3);  hold(6, 8'h04, 8'h04, "ch2_dutyeqper");
      wr(6'd18, 16'd0);
      settle(12); hold(12, 8'h44, 8'h00, "ch2_per0");
      wr(6'd16, 16'h0003);
      settle(3);  hold(12, 8'h44, 8'h04, "ch2_per0_pol1");

      // ch3 disable mid-period with polarity 1, then re-enable.
      wr(6'd26, 16'd10);
      wr(6'd28, 16'd3);
      wr(6'd24, 16'h0003);
      expect_pwm(8'h08, 8'h00, "ch3_run");
      drive(1'b1, 1'b0, 6'd24, 16'h0002, 16'h0, "");
      expect_pwm(8'h08, 8'h00, "ch3_dis_t1");
      rd(6'd30, 16'd0, "ch3_cnt_lo_dis");
      expect_pwm(8'h08, 8'h08, "ch3_dis_t2");
      rd(6'd29, 16'd0, "ch3_cnt_hi_dis");
      hold(3, 8'h08, 8'h08, "ch3_dis_idle");
      wr(6'd24, 16'h0003);
      for (int k = 1; k < 15; k++) begin
         p = (k < 2) ? 1'b1 : !(((k - 2) % 10) < 3);
         t = (k >= 2) && (((k - 2) % 10) == 9);
         expect_pwm(8'h88, {t, 3'b000, p, 3'b000}, "ch3_reenable");
         if (k == 1)      rd(6'd30, 16'd0, "ch3_cnt_restart");
         else if (k == 3) rd(6'd30, 16'd2, "ch3_cnt_count");
         else             step();
      end

      // Asynchronous reset with every channel active.
      expect_pwm(8'h04, 8'h04, "pre_reset_ch2");
      step();
      #2 reset_n = 1'b0;
      expect_pwm(8'hff, 8'h00, "reset_async");
      step();
      hold(2, 8'hff, 8'h00, "reset_held");
      reset_n = 1'b1;
      for (int a = 0; a < 32; a++)
         rd(6'(a), 16'h0, $sformatf("post_reset_rd%0d", a));
      hold(4, 8'hff, 8'h00, "post_reset_idle");
      wr(6'd42, 16'hABCD);
      wr(6'd40, 16'h0001);
      rd(6'd42, 16'h0, "ch5_readback");
      rd(6'd10, 16'h0, "ch5_no_alias");
      wr(6'd7, 16'h0001);
      rd(6'd7, 16'h0, "status_ro");
      drive(1'b1, 1'b1, 6'd4, 16'h0009, 16'h0000, "rdwr_same_addr");
      rd(6'd4, 16'h0009, "rd_after_wr");
      settle(3);

      n_vec++;
      if (rd_q.size() != 0 || pwm_q.size() != 0) begin
         n_fail++;
         $display("FAIL queues_drained: rd %0d pwm %0d left, want 0 0", rd_q.size(), pwm_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end
endmodule
